// File: rtl/square_seq_if.sv
// Handshake bundle for square_seq.
//   master: operand producer / result consumer (drives in_value, in_valid, out_ready)
//   slave : square_seq itself (drives in_ready, out_value, out_valid, busy)
interface square_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0]   in_value;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] out_value;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output in_value, in_valid, out_ready,
    input  in_ready, out_value, out_valid, busy
  );

  modport slave (
    input  in_value, in_valid, out_ready,
    output in_ready, out_value, out_valid, busy
  );
endinterface

// File: rtl/square_seq.sv
// square_seq: sequential unsigned squarer, out_value = in_value * in_value,
// one multiplier bit per clock by shift-add.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   bus   : square_seq_if.slave
//             in_value/in_valid/in_ready    operand handshake
//             out_value/out_valid/out_ready result handshake (2*WIDTH bits)
//             busy                          high in CALC or DONE
// Optional macro SQUARE_EARLY_EXIT_EN: leave CALC as soon as the remaining
// multiplier bits are zero (latency = max(1, bitlength(in_value))).
// Without it the latency is fixed at WIDTH cycles. Results are identical.
module square_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  square_seq_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [2*WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0]   mplr_q,      mplr_d;
  logic [2*WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [2*WIDTH-1:0] out_value_q, out_value_d;
  logic               out_valid_q, out_valid_d;

  logic [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]   mplr_shift;
  logic               last_step;

  always_comb begin
    sum        = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    mplr_shift = mplr_q >> 1;
`ifdef SQUARE_EARLY_EXIT_EN
    last_step  = (mplr_shift == '0);
`else
    last_step  = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    state_d     = state_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d = {{WIDTH{1'b0}}, bus.in_value};
          mplr_d  = bus.in_value;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) begin
          // final sum goes straight to the output register, not via acc
          out_value_d = sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && rst_n;
  assign bus.busy      = (state_q == CALC) || (state_q == DONE);
  assign bus.out_value = out_value_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_square_seq.sv
// Scoreboard bench for square_seq (WIDTH = 32). The driver pushes the
// expected square, operand and arrival cycle at each accept; the monitor
// compares when out_valid rises and pops on the result handshake.
module tb_square_seq;

  localparam int unsigned W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [63:0] val;
    logic [31:0] op;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];

  square_seq_if #(.WIDTH(W)) bus ();

  square_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] isqrt(input logic [63:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      logic [31:0] t;
      t = r | (32'd1 << i);
      if ((64'(t) * 64'(t)) <= x) r = t;
    end
    return r;
  endfunction

  function automatic int unsigned exp_lat(input logic [31:0] v);
    int unsigned n;
    n = W;
`ifdef SQUARE_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
`endif
    return n;
  endfunction

  // ---------------- monitor ----------------
  logic        seen = 1'b0;
  logic [63:0] held;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (!seen) begin
        seen = 1'b1;
        held = bus.out_value;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h want no out_valid", bus.out_value);
        end else begin
          chk("result", bus.out_value, exp_q[0].val);
          chk("latency", 64'(cyc), 64'(exp_q[0].cyc));
          chk("sqrt_roundtrip", 64'(isqrt(bus.out_value)), 64'(exp_q[0].op));
        end
      end else begin
        chk("out_value_stable", bus.out_value, held);
      end
      if (bus.out_ready === 1'b1) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
  task automatic send(input logic [31:0] v, input logic [63:0] want, input bit push);
    int unsigned n;
    @(posedge clk); #1;
    bus.in_value = v;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    end else if (push) begin
      exp_t e;
      e.val = want;
      e.op  = v;
      e.cyc = cyc + 1 + exp_lat(v);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_value = 32'hDEAD_BEEF;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy === 1'b1) && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int unsigned n;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_out_value", bus.out_value, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // basic and extreme operands
    send(32'd10, 64'd100, 1'b1);
    wait_idle();
    send(32'd0, 64'd0, 1'b1);
    wait_idle();
    send(32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_idle();

    // backpressure: result held while out_ready is low
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'd12, 64'd144, 1'b1);
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_value", bus.out_value, 64'd144);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_idle_busy", 64'(bus.busy), 64'd0);
    chk("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_out_value_kept", bus.out_value, 64'd144);
    wait_idle();

    // abort by reset at cnt == 10
    send(32'd7, 64'd49, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_in_ready_low", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_out_value", bus.out_value, 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("abort_no_result", 64'(bus.out_valid), 64'd0);
    send(32'd3, 64'd9, 1'b1);
    wait_idle();

    // small operands, back to back
    for (int i = 0; i <= 10; i++) send(32'(i), 64'(i * i), 1'b1);
    wait_idle();

    // random 16-bit and 32-bit operands
    for (int i = 0; i < 10; i++) begin
      r = 32'($urandom_range(65535));
      send(r, 64'(r) * 64'(r), 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      send(r, 64'(r) * 64'(r), 1'b1);
    end
    wait_idle();

    // early-exit corner operands (fixed latency when the option is off)
    send(32'd5, 64'd25, 1'b1);
    send(32'd0, 64'd0, 1'b1);
    send(32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
